ros2_pub_msg_sequencer: RTL
===========================

Name: ros2_pub_msg_sequencer

Overview:
Generates the published ROS2 message for the ros2_ether core. The message is a configurable ASCII prefix, followed by a DIGITS-wide decimal sequence number and a NUL terminator. The block drives the core's ros2_pub_app_data / ros2_pub_app_data_len inputs. Each update is one req/grant/rel transaction with the core, so the core never transmits a half-written message.

Parameters:
MAX_LEN, 64, byte capacity of app_data; equals ROS2_MAX_APP_DATA_LEN.
DIGITS, 5, decimal digits in the sequence number (BCD).
PERIOD, 12500000, clk_int cycles between automatic updates.
GRANT_TIMEOUT, 1024, cycles to wait for grant before abandoning a request.

Ports:
clk_int  in  1  clock
rst_n  in  1  reset
en  in  1  enables periodic and triggered updates
trigger  in  1  single-cycle pulse requesting an immediate update
prefix  in  MAX_LEN*8  prefix string; byte i at bits [8i+7:8i]
prefix_len  in  8  prefix length in bytes
app_data  out  MAX_LEN*8  message to core; byte i at bits [8i+7:8i]
app_data_len  out  8  message length including NUL
app_data_req  out  1  buffer access request to core
app_data_rel  out  1  one-cycle release pulse to core
app_data_grant  in  1  core grants buffer access
seq_count  out  DIGITS*4  current BCD sequence number
busy  out  1  high in any state other than IDLE
update_done  out  1  one-cycle pulse on successful update
err  out  1  one-cycle pulse on grant timeout or grant loss

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk_int. All outputs, app_data, app_data_len, seq_count and internal counters reset to 0. State is IDLE.
- Effective prefix length: eplen = min(prefix_len, MAX_LEN-DIGITS-1).
- Message length: mlen = eplen+DIGITS+1 (8-bit).
- eplen and mlen are latched on entry to REQ. prefix is sampled live during WRITE and must be held stable by the user while busy.
- IDLE:
  - The period counter counts while en=1 and is held at 0 while en=0.
  - Start condition: (trigger & en) or period counter == PERIOD-1.
  - On start: go to REQ and clear the period counter.
  - trigger and period expiry in the same cycle start one transaction only.
- REQ:
  - app_data_req=1.
  - The timeout counter increments each cycle.
  - If app_data_grant=1 is sampled: go to WRITE with idx=0.
  - If GRANT_TIMEOUT cycles pass without grant: app_data_req drops, err pulses, go to IDLE. seq_count is unchanged.
- WRITE:
  - app_data_req stays 1. One byte is written per cycle at idx, then idx increments.
  - Byte value:
    - idx<eplen: prefix byte idx.
    - eplen<=idx<eplen+DIGITS: 8'h30+BCD digit, most significant digit first.
    - Otherwise: 8'h00.
  - WRITE lasts exactly mlen cycles.
  - On the last byte, app_data_len<=mlen in the same edge, then go to REL.
  - Bytes at index >= mlen keep their prior values.
- Grant loss in WRITE: if app_data_grant=0 is sampled in WRITE, abort.
  - Go to REL.
  - err pulses in the REL cycle.
  - app_data_len is not updated and seq_count is not incremented; bytes already written stay written.
- REL:
  - app_data_req=0 and app_data_rel=1 for exactly one cycle.
  - On a successful write: update_done=1 in the same cycle, and seq_count does a BCD increment, wrapping all-9s to all-0s.
  - Go to IDLE.
- Latency:
  - Start sampled at edge T gives req=1 after T.
  - Grant sampled at edge G puts the first byte visible after G+1.
  - rel is high in the cycle after the last byte.
  - req is continuously high from REQ entry until the REL cycle.
- en falling while busy: the transaction completes normally. trigger is ignored while busy.
- Asynchronous reset mid-transaction: req and rel drop immediately and all state clears. The core observes a req drop without rel; the core treats that as a release.

Test Plan:
- Single update:
  - Stimulus: reset; prefix="hi " (len 3), DIGITS=5; en=1; trigger pulse; grant tied 1.
  - Response: req=1 the cycle after trigger; 9 WRITE cycles; app_data bytes "hi 00000",8'h00; app_data_len=9; one-cycle rel together with update_done; seq_count=0x00001.
- Periodic updates:
  - Stimulus: PERIOD=100, no trigger.
  - Response: transactions start every 100 cycles plus transaction duration; the second message digits read "00001"; seq_count=0x00002.
- Grant timeout:
  - Stimulus: GRANT_TIMEOUT=16, grant held 0.
  - Response: req is high for exactly 16 cycles, then drops; err pulses once; no rel; seq_count and app_data_len unchanged.
- Grant loss and late grant:
  - Stimulus A: grant deasserted after 4 WRITE cycles.
  - Response A: rel and err pulse together; app_data_len stays at its previous value; seq_count unchanged.
  - Stimulus B: next attempt with grant asserted on the 5th REQ cycle.
  - Response B: the update succeeds.
- Clamp and wrap:
  - Stimulus A: prefix_len=200, MAX_LEN=64, DIGITS=5.
  - Response A: eplen=58, app_data_len=64, and byte 63 = 8'h00.
  - Stimulus B: force seq_count to 0x99999 and run one update.
  - Response B: digits read "99999"; seq_count then wraps to 0x00000.
- Simultaneous events and reset:
  - Stimulus A: trigger coincides with period expiry.
  - Response A: exactly one transaction.
  - Stimulus B: trigger while busy.
  - Response B: ignored.
  - Stimulus C: en dropped mid-WRITE.
  - Response C: completes with update_done.
  - Stimulus D: rst_n asserted mid-WRITE.
  - Response D: all outputs are 0 asynchronously.

Source files
------------

// File: rtl/ros2_pub_msg_sequencer.sv
// Builds "<prefix><DIGITS-digit BCD sequence>\0" into the ros2_ether app_data buffer,
// one req/grant/rel transaction per update so the core never sees a partial message.
module ros2_pub_msg_sequencer #(
    parameter int unsigned MAX_LEN       = 64,
    parameter int unsigned DIGITS        = 5,
    parameter int unsigned PERIOD        = 12500000,
    parameter int unsigned GRANT_TIMEOUT = 1024
) (
    input  logic                  clk_int,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  trigger,
    input  logic [MAX_LEN*8-1:0]  prefix,
    input  logic [7:0]            prefix_len,
    output logic [MAX_LEN*8-1:0]  app_data,
    output logic [7:0]            app_data_len,
    output logic                  app_data_req,
    output logic                  app_data_rel,
    input  logic                  app_data_grant,
    output logic [DIGITS*4-1:0]   seq_count,
    output logic                  busy,
    output logic                  update_done,
    output logic                  err
);

    localparam int unsigned PCW      = $clog2(PERIOD + 1);
    localparam int unsigned TCW      = $clog2(GRANT_TIMEOUT + 1);
    localparam int unsigned PLEN_MAX = MAX_LEN - DIGITS - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_REL   = 2'd3;

    logic [1:0]             r_state;
    logic [PCW-1:0]         r_period_cnt;
    logic [TCW-1:0]         r_to_cnt;
    logic [7:0]             r_idx;
    logic [7:0]             r_eplen;
    logic [7:0]             r_mlen;
    logic [MAX_LEN*8-1:0]   r_app_data;
    logic [7:0]             r_len;
    logic [DIGITS*4-1:0]    r_seq;
    logic                   r_req;
    logic                   r_rel;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;

    logic [1:0]             w_state_nxt;
    logic                   w_start;
    logic                   w_timeout;
    logic                   w_abort;
    logic                   w_last;
    logic [7:0]             w_eplen;
    logic [7:0]             w_mlen;
    logic [7:0]             w_didx;
    logic [7:0]             w_pbyte;
    logic [3:0]             w_digit;
    logic [7:0]             w_byte;
    logic [DIGITS*4-1:0]    w_seq_inc;
    logic                   w_carry;

    assign w_eplen = (prefix_len > 8'(PLEN_MAX)) ? 8'(PLEN_MAX) : prefix_len;
    assign w_mlen  = w_eplen + 8'(DIGITS + 1);

    // State register
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and transition qualifiers
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_timeout   = 1'b0;
        w_abort     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start = (trigger & en) | (r_period_cnt == PCW'(PERIOD - 1));
                if (w_start) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (app_data_grant) begin
                    w_state_nxt = S_WRITE;
                end else if (r_to_cnt == TCW'(GRANT_TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                if (!app_data_grant) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_REL;
                end else if (r_idx == r_mlen - 8'd1) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_REL;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Message byte at r_idx: prefix, then ASCII digits MSD first, then NUL
    always_comb begin
        w_pbyte = 8'h00;
        w_digit = 4'h0;
        w_byte  = 8'h00;
        w_didx  = r_idx - r_eplen;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (r_idx == 8'(i)) w_pbyte = prefix[i*8 +: 8];
        end
        for (int d = 0; d < DIGITS; d++) begin
            if (w_didx == 8'(d)) w_digit = r_seq[(DIGITS-1-d)*4 +: 4];
        end
        if (r_idx < r_eplen)                     w_byte = w_pbyte;
        else if (r_idx < r_eplen + 8'(DIGITS))   w_byte = 8'h30 + {4'h0, w_digit};
    end

    // BCD increment with all-9s wrapping to zero
    always_comb begin
        w_carry   = 1'b1;
        w_seq_inc = r_seq;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_carry) begin
                if (r_seq[d*4 +: 4] == 4'd9) begin
                    w_seq_inc[d*4 +: 4] = 4'd0;
                end else begin
                    w_seq_inc[d*4 +: 4] = r_seq[d*4 +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            r_period_cnt <= '0;
            r_to_cnt     <= '0;
            r_idx        <= '0;
            r_eplen      <= '0;
            r_mlen       <= '0;
            r_app_data   <= '0;
            r_len        <= '0;
            r_seq        <= '0;
            r_req        <= 1'b0;
            r_rel        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (r_state == S_IDLE && en && !w_start) r_period_cnt <= r_period_cnt + PCW'(1);
            else                                     r_period_cnt <= '0;

            if (r_state == S_REQ && w_state_nxt == S_REQ) r_to_cnt <= r_to_cnt + TCW'(1);
            else                                          r_to_cnt <= '0;

            if (w_start) begin
                r_eplen <= w_eplen;
                r_mlen  <= w_mlen;
            end

            if (r_state == S_WRITE) r_idx <= r_idx + 8'd1;
            else                    r_idx <= '0;

            for (int i = 0; i < MAX_LEN; i++) begin
                if (r_state == S_WRITE && app_data_grant && r_idx == 8'(i))
                    r_app_data[i*8 +: 8] <= w_byte;
            end

            if (w_last) begin
                r_len <= r_mlen;
                r_seq <= w_seq_inc;
            end

            r_req  <= (w_state_nxt == S_REQ) || (w_state_nxt == S_WRITE);
            r_rel  <= (w_state_nxt == S_REL);
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= w_last;
            r_err  <= w_timeout | w_abort;
        end
    end

    assign app_data     = r_app_data;
    assign app_data_len = r_len;
    assign app_data_req = r_req;
    assign app_data_rel = r_rel;
    assign seq_count    = r_seq;
    assign busy         = r_busy;
    assign update_done  = r_done;
    assign err          = r_err;

endmodule
